// File: rtl/tm1638_frame_sequencer.sv
// TM1638 frame sequencer: reads the display frame buffer and emits mode, address+data burst and control words to spi_fifo.
// Latency: 3*2 + NUM_BYTES*4 + 1 cycles from the accepted start to o_Done while the FIFO never reports full.
// Backpressure: waits on i_FIFO_Full before every push; a gap cycle follows each push so the full flag can settle.
module tm1638_frame_sequencer #(
    parameter int NUM_BYTES      = 16,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    input  logic        i_Display_On,
    input  logic [2:0]  i_Brightness,
    output logic [3:0]  o_Buf_Addr,
    input  logic [7:0]  i_Buf_Data,
    input  logic        i_FIFO_Full,
    output logic        o_Data_Valid,
    output logic [17:0] o_Data,
    output logic        o_Busy,
    output logic        o_Done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_MODE,
        S_ADDR,
        S_RD,
        S_LD,
        S_DATA,
        S_CTRL,
        S_GAP,
        S_FIN
    } state_t;

    localparam logic [3:0]  LAST_IDX     = 4'(NUM_BYTES - 1);
    localparam logic        REFRESH_EN   = (REFRESH_CYCLES > 0);
    localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);

    // Command bytes of the TM1638 protocol.
    localparam logic [7:0] CMD_MODE = 8'h40;  // data write, auto-increment address
    localparam logic [7:0] CMD_ADDR = 8'hC0;  // start at display address 0

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;          // where the gap cycle hands control back to
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic        on_q, on_d;
    logic [2:0]  bright_q, bright_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [17:0] data_q, data_d;
    logic [3:0]  addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        refresh_hit;

    // FIFO word: upper bits unused, bit 8 releases STB after this byte.
    function automatic logic [17:0] fifo_word(input logic stb_end, input logic [7:0] b);
        return {9'd0, stb_end, b};
    endfunction

    assign refresh_hit = REFRESH_EN && (cnt_q == REFRESH_LAST);

    // Next-state and registered-output logic of the frame sequencer.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        on_d     = on_q;
        bright_d = bright_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = REFRESH_EN ? cnt_q + 32'd1 : 32'd0;
                // A start arriving in the o_Done cycle is dropped; a refresh hit is not.
                if ((i_Start && !done_q) || refresh_hit) begin
                    on_d     = i_Display_On;
                    bright_d = i_Brightness;
                    busy_d   = 1'b1;
                    idx_d    = 4'd0;
                    cnt_d    = 32'd0;
                    state_d  = S_MODE;
                end
            end
            S_MODE: begin
                if (!i_FIFO_Full) begin
                    valid_d = 1'b1;
                    data_d  = fifo_word(1'b1, CMD_MODE);
                    ret_d   = S_ADDR;
                    state_d = S_GAP;
                end
            end
            S_ADDR: begin
                if (!i_FIFO_Full) begin
                    valid_d = 1'b1;
                    data_d  = fifo_word(1'b0, CMD_ADDR);
                    ret_d   = S_RD;
                    state_d = S_GAP;
                end
            end
            S_RD: begin
                // o_Buf_Addr already follows idx, so the buffer sees it this cycle.
                state_d = S_LD;
            end
            S_LD: begin
                byte_d  = i_Buf_Data;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (!i_FIFO_Full) begin
                    valid_d = 1'b1;
                    data_d  = fifo_word(idx_q == LAST_IDX, byte_q);
                    state_d = S_GAP;
                    if (idx_q == LAST_IDX) begin
                        ret_d = S_CTRL;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        ret_d = S_RD;
                    end
                end
            end
            S_CTRL: begin
                if (!i_FIFO_Full) begin
                    valid_d = 1'b1;
                    data_d  = fifo_word(1'b1, {4'b1000, on_q, bright_q});
                    ret_d   = S_FIN;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = ret_q;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        addr_d = idx_d;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            ret_q    <= S_IDLE;
            idx_q    <= 4'd0;
            byte_q   <= 8'd0;
            on_q     <= 1'b0;
            bright_q <= 3'd0;
            cnt_q    <= 32'd0;
            valid_q  <= 1'b0;
            data_q   <= 18'd0;
            addr_q   <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            on_q     <= on_d;
            bright_q <= bright_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_Buf_Addr   = addr_q;
    assign o_Data_Valid = valid_q;
    assign o_Data       = data_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;

endmodule
